// File: rtl/fencing_action_ctrl.sv
// Per-player fencing action controller: latches IR buttons between frame strobes, advances the
// action FSM once per accepted strobe and publishes a registered snapshot with a valid pulse.
module fencing_action_ctrl #(
    parameter int X_W            = 11,
    parameter int Y_W            = 10,
    parameter int HEALTH_W       = 3,
    parameter int HEALTH_INIT    = 5,
    parameter int LUNGE_FRAMES   = 2,
    parameter int ATTACK_FRAMES  = 30,
    parameter int BLOCK_FRAMES   = 60,
    parameter int RECOVER_FRAMES = 20
) (
    input  logic                clk_pixel_in,
    input  logic                rst_n_in,
    input  logic                ir_valid_in,
    input  logic                block_in,
    input  logic                lunge_in,
    input  logic                release_in,
    input  logic                step_in,
    input  logic [X_W-1:0]      saber_x_in,
    input  logic [Y_W-1:0]      saber_y_in,
    input  logic                sabers_colliding_in,
    input  logic                attack_hit_in,
    input  logic                opponent_scored_in,
    output logic [1:0]          saber_state_out,
    output logic [X_W-1:0]      attack_x_out,
    output logic [Y_W-1:0]      attack_y_out,
    output logic [HEALTH_W-1:0] health_out,
    output logic                scored_out,
    output logic                game_over_out,
    output logic                data_out_valid
);
    typedef enum logic [2:0] {
        ST_REST, ST_LUNGE, ST_BLOCK, ST_ATTACK, ST_SCORE, ST_RECOVER, ST_DEAD
    } state_t;

    localparam int MAX_AB     = (ATTACK_FRAMES > BLOCK_FRAMES) ? ATTACK_FRAMES : BLOCK_FRAMES;
    localparam int MAX_LR     = (LUNGE_FRAMES > RECOVER_FRAMES) ? LUNGE_FRAMES : RECOVER_FRAMES;
    localparam int MAX_FRAMES = (MAX_AB > MAX_LR) ? MAX_AB : MAX_LR;
    localparam int FC_W       = $clog2(MAX_FRAMES + 1);

    localparam logic [FC_W-1:0]     LUNGE_LAST   = FC_W'(LUNGE_FRAMES - 1);
    localparam logic [FC_W-1:0]     ATTACK_LAST  = FC_W'(ATTACK_FRAMES - 1);
    localparam logic [FC_W-1:0]     BLOCK_LAST   = FC_W'(BLOCK_FRAMES - 1);
    localparam logic [FC_W-1:0]     RECOVER_LAST = FC_W'(RECOVER_FRAMES - 1);
    localparam logic [HEALTH_W-1:0] HEALTH_RST   = HEALTH_W'(HEALTH_INIT);

    state_t              state;
    logic [FC_W-1:0]     fc;
    logic [HEALTH_W-1:0] health;
    logic [X_W-1:0]      atk_x;
    logic [Y_W-1:0]      atk_y;
    logic                block_l, lunge_l, release_l;
    logic                step_d;

    logic                step_ok, block_now, lunge_now, release_now;
    logic [HEALTH_W-1:0] health_nx;

    // A strobe directly after an accepted one is dropped; a same-cycle IR sample joins the step.
    assign step_ok     = step_in && !step_d;
    assign block_now   = block_l   || (ir_valid_in && block_in);
    assign lunge_now   = lunge_l   || (ir_valid_in && lunge_in);
    assign release_now = release_l || (ir_valid_in && release_in);
    assign health_nx   = (opponent_scored_in && health != '0) ? health - 1'b1 : health;

    function automatic logic [1:0] encode(input state_t s);
        case (s)
            ST_LUNGE:  return 2'b01;
            ST_BLOCK:  return 2'b10;
            ST_ATTACK: return 2'b11;
            default:   return 2'b00;
        endcase
    endfunction

    always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state           <= ST_REST;
            fc              <= '0;
            health          <= HEALTH_RST;
            atk_x           <= '0;
            atk_y           <= '0;
            block_l         <= 1'b0;
            lunge_l         <= 1'b0;
            release_l       <= 1'b0;
            step_d          <= 1'b0;
            saber_state_out <= 2'b00;
            attack_x_out    <= '0;
            attack_y_out    <= '0;
            health_out      <= HEALTH_RST;
            scored_out      <= 1'b0;
            game_over_out   <= 1'b0;
            data_out_valid  <= 1'b0;
        end else begin
            step_d         <= step_ok;
            data_out_valid <= step_d;

            if (step_ok) begin
                block_l   <= 1'b0;
                lunge_l   <= 1'b0;
                release_l <= 1'b0;
            end else if (ir_valid_in) begin
                block_l   <= block_l   | block_in;
                lunge_l   <= lunge_l   | lunge_in;
                release_l <= release_l | release_in;
            end

            // fc counts up by default; every transition below restarts it at zero.
            if (step_ok) begin
                health <= health_nx;
                fc     <= fc + 1'b1;
                if (health_nx == '0 && state != ST_DEAD) begin
                    state <= ST_DEAD;
                    fc    <= '0;
                end else begin
                    case (state)
                        ST_REST: begin
                            if (block_now) begin
                                state <= ST_BLOCK;
                                fc    <= '0;
                            end else if (lunge_now) begin
                                state <= ST_LUNGE;
                                fc    <= '0;
                                atk_x <= saber_x_in;
                                atk_y <= saber_y_in;
                            end
                        end
                        ST_BLOCK: begin
                            if (release_now) begin
                                state <= ST_REST;
                                fc    <= '0;
                            end else if (fc == BLOCK_LAST) begin
                                state <= ST_RECOVER;
                                fc    <= '0;
                            end
                        end
                        ST_LUNGE: begin
                            if (fc == LUNGE_LAST) begin
                                state <= ST_ATTACK;
                                fc    <= '0;
                            end
                        end
                        ST_ATTACK: begin
                            if (release_now && attack_hit_in) begin
                                state <= ST_SCORE;
                                fc    <= '0;
                            end else if (sabers_colliding_in || release_now || fc == ATTACK_LAST) begin
                                state <= ST_RECOVER;
                                fc    <= '0;
                            end
                        end
                        ST_SCORE: begin
                            state <= ST_RECOVER;
                            fc    <= '0;
                        end
                        ST_RECOVER: begin
                            if (fc == RECOVER_LAST) begin
                                state <= ST_REST;
                                fc    <= '0;
                            end
                        end
                        default: ;
                    endcase
                end
            end

            if (step_d) begin
                saber_state_out <= encode(state);
                attack_x_out    <= (state == ST_LUNGE || state == ST_ATTACK) ? atk_x : '0;
                attack_y_out    <= (state == ST_LUNGE || state == ST_ATTACK) ? atk_y : '0;
                health_out      <= health;
                scored_out      <= (state == ST_SCORE);
                game_over_out   <= (health == '0);
            end
        end
    end
endmodule

// File: tb/tb_fencing_action_ctrl.sv
// Self-checking bench for fencing_action_ctrl: fixed vector table, hand-written corner sequences
// and randomized steps compared against a rule-level reference model.
module tb_fencing_action_ctrl;
    localparam int X_W            = 11;
    localparam int Y_W            = 10;
    localparam int HEALTH_W       = 3;
    localparam int HEALTH_INIT    = 5;
    localparam int LUNGE_FRAMES   = 2;
    localparam int ATTACK_FRAMES  = 30;
    localparam int BLOCK_FRAMES   = 60;
    localparam int RECOVER_FRAMES = 20;

    localparam int P_REST = 0, P_LUNGE = 1, P_BLOCK = 2, P_ATTACK = 3;
    localparam int P_SCORE = 4, P_RECOVER = 5, P_DEAD = 6;

    logic                clk_pixel_in = 1'b0;
    logic                rst_n_in = 1'b0;
    logic                ir_valid_in = 1'b0, block_in = 1'b0, lunge_in = 1'b0, release_in = 1'b0;
    logic                step_in = 1'b0;
    logic [X_W-1:0]      saber_x_in = '0;
    logic [Y_W-1:0]      saber_y_in = '0;
    logic                sabers_colliding_in = 1'b0, attack_hit_in = 1'b0, opponent_scored_in = 1'b0;
    logic [1:0]          saber_state_out;
    logic [X_W-1:0]      attack_x_out;
    logic [Y_W-1:0]      attack_y_out;
    logic [HEALTH_W-1:0] health_out;
    logic                scored_out, game_over_out, data_out_valid;

    int compared = 0;
    int mismatched = 0;

    int m_phase, m_age, m_health, m_ax, m_ay;
    bit m_blk, m_lng, m_rel;

    typedef struct {
        bit b, l, r, col, hit, opp;
        int x, y;
        int st, h;
        bit sc, go;
        int ex, ey;
    } vec_t;

    vec_t vecs[6];

    always #5 clk_pixel_in = ~clk_pixel_in;

    fencing_action_ctrl #(
        .X_W(X_W), .Y_W(Y_W), .HEALTH_W(HEALTH_W), .HEALTH_INIT(HEALTH_INIT),
        .LUNGE_FRAMES(LUNGE_FRAMES), .ATTACK_FRAMES(ATTACK_FRAMES),
        .BLOCK_FRAMES(BLOCK_FRAMES), .RECOVER_FRAMES(RECOVER_FRAMES)
    ) dut (
        .clk_pixel_in(clk_pixel_in), .rst_n_in(rst_n_in), .ir_valid_in(ir_valid_in),
        .block_in(block_in), .lunge_in(lunge_in), .release_in(release_in), .step_in(step_in),
        .saber_x_in(saber_x_in), .saber_y_in(saber_y_in),
        .sabers_colliding_in(sabers_colliding_in), .attack_hit_in(attack_hit_in),
        .opponent_scored_in(opponent_scored_in), .saber_state_out(saber_state_out),
        .attack_x_out(attack_x_out), .attack_y_out(attack_y_out), .health_out(health_out),
        .scored_out(scored_out), .game_over_out(game_over_out), .data_out_valid(data_out_valid)
    );

    task automatic checkOutput(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic checkSnapshot(input string name, input int st, input int h, input bit sc,
                                 input bit go, input int ex, input int ey);
        checkOutput({name, ".state"}, int'(saber_state_out), st);
        checkOutput({name, ".health"}, int'(health_out), h);
        checkOutput({name, ".scored"}, int'(scored_out), int'(sc));
        checkOutput({name, ".game_over"}, int'(game_over_out), int'(go));
        checkOutput({name, ".attack_x"}, int'(attack_x_out), ex);
        checkOutput({name, ".attack_y"}, int'(attack_y_out), ey);
    endtask

    task automatic modelReset();
        m_phase  = P_REST;
        m_age    = 0;
        m_health = HEALTH_INIT;
        m_ax     = 0;
        m_ay     = 0;
        m_blk    = 0;
        m_lng    = 0;
        m_rel    = 0;
    endtask

    // One frame of the game rules, applied to buttons remembered since the previous frame.
    task automatic modelStep(input bit b, input bit l, input bit r, input bit col, input bit hit,
                             input bit opp, input int x, input int y);
        bit eb, el, er;
        int nxt;
        eb = m_blk | b;
        el = m_lng | l;
        er = m_rel | r;
        m_blk = 0;
        m_lng = 0;
        m_rel = 0;
        if (opp && m_health > 0) m_health--;
        nxt = m_phase;
        if (m_phase == P_DEAD || m_health == 0) nxt = P_DEAD;
        else if (m_phase == P_REST) begin
            if (eb) nxt = P_BLOCK;
            else if (el) begin
                nxt  = P_LUNGE;
                m_ax = x;
                m_ay = y;
            end
        end else if (m_phase == P_BLOCK) begin
            if (er) nxt = P_REST;
            else if (m_age + 1 >= BLOCK_FRAMES) nxt = P_RECOVER;
        end else if (m_phase == P_LUNGE) begin
            if (m_age + 1 >= LUNGE_FRAMES) nxt = P_ATTACK;
        end else if (m_phase == P_ATTACK) begin
            if (er && hit) nxt = P_SCORE;
            else if (col || er || m_age + 1 >= ATTACK_FRAMES) nxt = P_RECOVER;
        end else if (m_phase == P_SCORE) nxt = P_RECOVER;
        else if (m_phase == P_RECOVER) begin
            if (m_age + 1 >= RECOVER_FRAMES) nxt = P_REST;
        end
        m_age   = (nxt == m_phase) ? m_age + 1 : 0;
        m_phase = nxt;
    endtask

    task automatic checkModel(input string name);
        int st;
        bit armed;
        armed = (m_phase == P_LUNGE || m_phase == P_ATTACK);
        st = (m_phase == P_LUNGE) ? 1 : (m_phase == P_BLOCK) ? 2 : (m_phase == P_ATTACK) ? 3 : 0;
        checkSnapshot(name, st, m_health, m_phase == P_SCORE, m_health == 0,
                      armed ? m_ax : 0, armed ? m_ay : 0);
    endtask

    task automatic resetDut();
        rst_n_in = 1'b0;
        ir_valid_in = 0; block_in = 0; lunge_in = 0; release_in = 0; step_in = 0;
        sabers_colliding_in = 0; attack_hit_in = 0; opponent_scored_in = 0;
        repeat (2) @(negedge clk_pixel_in);
        rst_n_in = 1'b1;
        @(negedge clk_pixel_in);
        modelReset();
    endtask

    task automatic pressButtons(input bit b, input bit l, input bit r);
        @(negedge clk_pixel_in);
        ir_valid_in = 1; block_in = b; lunge_in = l; release_in = r;
        m_blk |= b;
        m_lng |= l;
        m_rel |= r;
        @(negedge clk_pixel_in);
        ir_valid_in = 0; block_in = 0; lunge_in = 0; release_in = 0;
    endtask

    // Drives one strobe with a coincident IR sample and waits for the resulting snapshot.
    task automatic applyStimulus(input bit b, input bit l, input bit r, input bit col,
                                 input bit hit, input bit opp, input int x, input int y);
        @(negedge clk_pixel_in);
        ir_valid_in = b | l | r; block_in = b; lunge_in = l; release_in = r;
        step_in = 1;
        saber_x_in = X_W'(x);
        saber_y_in = Y_W'(y);
        sabers_colliding_in = col; attack_hit_in = hit; opponent_scored_in = opp;
        modelStep(b, l, r, col, hit, opp, x, y);
        @(negedge clk_pixel_in);
        ir_valid_in = 0; block_in = 0; lunge_in = 0; release_in = 0; step_in = 0;
        sabers_colliding_in = 0; attack_hit_in = 0; opponent_scored_in = 0;
        checkOutput("valid_before_snapshot", int'(data_out_valid), 0);
        @(negedge clk_pixel_in);
        checkOutput("valid_pulse", int'(data_out_valid), 1);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{0, 0, 0, 0, 0, 0,   5,   6, 0, 5, 0, 0,   0,   0};
        vecs[1] = '{0, 1, 0, 0, 0, 0, 100, 200, 1, 5, 0, 0, 100, 200};
        vecs[2] = '{0, 0, 1, 0, 0, 0,   7,   9, 1, 5, 0, 0, 100, 200};
        vecs[3] = '{0, 0, 0, 0, 0, 0,   7,   9, 3, 5, 0, 0, 100, 200};
        vecs[4] = '{0, 0, 1, 0, 1, 0,   7,   9, 0, 5, 1, 0,   0,   0};
        vecs[5] = '{0, 0, 0, 0, 0, 0,   7,   9, 0, 5, 0, 0,   0,   0};

        resetDut();
        checkSnapshot("reset", 0, HEALTH_INIT, 0, 0, 0, 0);
        checkOutput("reset.valid", int'(data_out_valid), 0);

        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].b, vecs[i].l, vecs[i].r, vecs[i].col, vecs[i].hit,
                          vecs[i].opp, vecs[i].x, vecs[i].y);
            checkSnapshot($sformatf("vec%0d", i), vecs[i].st, vecs[i].h, vecs[i].sc,
                          vecs[i].go, vecs[i].ex, vecs[i].ey);
        end
        for (int i = 0; i < RECOVER_FRAMES; i++) begin
            applyStimulus(0, 1, 0, 0, 0, 0, 1, 2);
            checkOutput($sformatf("recover%0d.state", i), int'(saber_state_out), 0);
        end
        applyStimulus(0, 1, 0, 0, 0, 0, 11, 22);
        checkSnapshot("after_recover", 1, 5, 0, 0, 11, 22);

        resetDut();
        applyStimulus(1, 1, 0, 0, 0, 0, 3, 4);
        checkOutput("block_entry.state", int'(saber_state_out), 2);
        for (int i = 1; i < BLOCK_FRAMES; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 3, 4);
            checkOutput($sformatf("block%0d.state", i), int'(saber_state_out), 2);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 3, 4);
        checkOutput("block_timeout.state", int'(saber_state_out), 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 3, 4);
        checkOutput("block_then_recover.state", int'(saber_state_out), 0);

        resetDut();
        applyStimulus(0, 1, 0, 0, 0, 0, 50, 60);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("clash_pre.state", int'(saber_state_out), 3);
        applyStimulus(0, 0, 0, 1, 1, 0, 0, 0);
        checkSnapshot("clash", 0, 5, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
        checkOutput("clash_recover.state", int'(saber_state_out), 0);

        resetDut();
        applyStimulus(0, 1, 0, 0, 0, 0, 50, 60);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i < ATTACK_FRAMES; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
            checkOutput($sformatf("attack%0d.state", i), int'(saber_state_out), 3);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("attack_timeout.state", int'(saber_state_out), 0);

        resetDut();
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
            checkSnapshot($sformatf("health%0d", i), 0, 5 - i, 0, i == 5, 0, 0);
        end
        applyStimulus(0, 1, 0, 0, 0, 0, 9, 9);
        checkSnapshot("dead_lunge", 0, 0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
        checkSnapshot("dead_sixth_hit", 0, 0, 0, 1, 0, 0);

        resetDut();
        applyStimulus(0, 1, 0, 0, 0, 0, 70, 80);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
        checkSnapshot("pre_async", 3, 4, 0, 0, 70, 80);
        @(posedge clk_pixel_in);
        #2 rst_n_in = 1'b0;
        #1;
        checkSnapshot("async_reset", 0, HEALTH_INIT, 0, 0, 0, 0);
        checkOutput("async_reset.valid", int'(data_out_valid), 0);
        @(negedge clk_pixel_in);
        rst_n_in = 1'b1;
        modelReset();

        resetDut();
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("coinc_block.state", int'(saber_state_out), 2);
        applyStimulus(0, 0, 1, 0, 0, 0, 0, 0);
        checkOutput("coinc_release.state", int'(saber_state_out), 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("coinc_not_retained.state", int'(saber_state_out), 0);

        resetDut();
        pressButtons(0, 1, 0);
        repeat (3) @(negedge clk_pixel_in);
        applyStimulus(0, 0, 0, 0, 0, 0, 33, 44);
        checkSnapshot("latched_lunge", 1, 5, 0, 0, 33, 44);

        resetDut();
        @(negedge clk_pixel_in);
        ir_valid_in = 1; lunge_in = 1; step_in = 1;
        saber_x_in = X_W'(55);
        saber_y_in = Y_W'(66);
        modelStep(0, 1, 0, 0, 0, 0, 55, 66);
        @(negedge clk_pixel_in);
        ir_valid_in = 0; lunge_in = 0;
        @(negedge clk_pixel_in);
        step_in = 0;
        checkOutput("double_strobe.valid", int'(data_out_valid), 1);
        checkSnapshot("double_strobe", 1, 5, 0, 0, 55, 66);
        @(negedge clk_pixel_in);
        checkOutput("double_strobe.valid_drop", int'(data_out_valid), 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("double_strobe_next.state", int'(saber_state_out), 1);

        for (int run = 0; run < 4; run++) begin
            resetDut();
            for (int k = 0; k < 120; k++) begin
                if ($urandom_range(0, 3) == 0)
                    pressButtons($urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
                                 $urandom_range(0, 5) == 0);
                applyStimulus($urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
                              $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                              $urandom_range(0, 1) == 1, $urandom_range(0, 29) == 0,
                              int'($urandom_range(0, 2047)), int'($urandom_range(0, 1023)));
                checkModel($sformatf("rand%0d_%0d", run, k));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/fencing_action_ctrl.md
Name: fencing_action_ctrl

Overview:
- Per-player fencing action controller. It is the parametrised successor of the single-cycle action FSM.
- It advances one state-machine step per frame strobe and latches IR button events between strobes.
- It adds frame-counted lunge, attack, block and recover timeouts, a parametrised health counter, a game-over lockout, and a registered output snapshot with a valid pulse.
- It sits between the IR decoder / frame syncer and the renderer / network packer.

Parameters:
- X_W, 11, saber x coordinate width
- Y_W, 10, saber y coordinate width
- HEALTH_W, 3, health counter width
- HEALTH_INIT, 5, health value after reset (must be ≤ 2^HEALTH_W−1)
- LUNGE_FRAMES, 2, steps spent in LUNGE before ATTACK (≥1)
- ATTACK_FRAMES, 30, maximum steps in ATTACK before forced RECOVER (≥1)
- BLOCK_FRAMES, 60, maximum steps in BLOCK before forced RECOVER (≥1)
- RECOVER_FRAMES, 20, steps spent in RECOVER before REST (≥1)

Ports:
- clk_pixel_in  in  1  pixel clock
- rst_n_in  in  1  asynchronous active-low reset
- ir_valid_in  in  1  button sample strobe
- block_in  in  1  block button, sampled on ir_valid_in
- lunge_in  in  1  lunge button, sampled on ir_valid_in
- release_in  in  1  release event, sampled on ir_valid_in
- step_in  in  1  frame strobe from syncer; one FSM step per pulse
- saber_x_in  in  X_W  current saber x, sampled on step_in
- saber_y_in  in  Y_W  current saber y, sampled on step_in
- sabers_colliding_in  in  1  saber-clash flag, sampled on step_in
- attack_hit_in  in  1  attack-path/opponent intersection flag, sampled on step_in
- opponent_scored_in  in  1  opponent scored, sampled on step_in
- saber_state_out  out  2  00 rest, 01 lunge, 10 block, 11 attack
- attack_x_out  out  X_W  saber x latched at lunge start (0 when not lunging/attacking)
- attack_y_out  out  Y_W  saber y latched at lunge start
- health_out  out  HEALTH_W  remaining health
- scored_out  out  1  player scored this step
- game_over_out  out  1  health reached 0
- data_out_valid  out  1  one-cycle pulse, outputs updated

Behaviour:
- Reset (async assert, sync release):
  - State REST; all counters 0; health_out=HEALTH_INIT; all other outputs 0; button latches cleared.
- Button latches:
  - On ir_valid_in, each latch ORs in its input (sticky).
  - All latches clear in the cycle step_in is consumed.
  - If ir_valid_in and step_in coincide, the new sample is used for that step and is not retained afterwards.
- Step processing:
  - On step_in, a step occurs in that cycle, using the latched buttons and the sampled inputs. State, counter and internal registers update at the clock edge ending that cycle.
  - Outputs update one cycle later, together with data_out_valid=1 for exactly one cycle.
  - step_in pulses closer than 2 cycles apart: the second pulse is ignored.
- State transitions, evaluated once per step. Frame counter fc resets to 0 on every state change and otherwise increments by 1 per step.
  - REST → BLOCK if block; else → LUNGE if lunge (latch attack x/y from saber_x_in/saber_y_in); else stay. Block has priority over lunge.
  - BLOCK → REST if release; else → RECOVER if fc==BLOCK_FRAMES−1.
  - LUNGE → ATTACK when fc==LUNGE_FRAMES−1. Release is ignored in LUNGE.
  - ATTACK, in priority order:
    - release & attack_hit → SCORE
    - sabers_colliding | release → RECOVER
    - fc==ATTACK_FRAMES−1 → RECOVER
  - SCORE → RECOVER after one step; scored_out=1 on that step's output snapshot only.
  - RECOVER → REST when fc==RECOVER_FRAMES−1. Buttons are ignored in RECOVER.
  - DEAD: entered from any state when health reaches 0. Only reset exits DEAD.
- saber_state_out encoding:
  - REST, SCORE, RECOVER, DEAD → 00; LUNGE → 01; BLOCK → 10; ATTACK → 11.
  - attack_x/y_out read 0 outside LUNGE/ATTACK.
- Health:
  - opponent_scored_in on a step decrements health, saturating at 0.
  - Reaching 0 sets game_over_out=1 and forces DEAD on the same step.
  - If the same step would move to SCORE, DEAD wins and scored_out stays 0.
- Reset mid-operation: all state, counters and health return to reset values immediately; data_out_valid deasserts.

Test Plan:
- Reset, then one step with no buttons → state_out=00, health_out=5, data_out_valid pulses exactly 1 cycle after step_in, scored_out=0.
- Lunge latched, then steps with saber at (100,200) → LUNGE for 2 steps (state 01, attack_x/y=100/200), then ATTACK (11). Release with attack_hit=1 → SCORE step has scored_out=1. Then 20 RECOVER steps (00) → REST.
- Block held with no release → BLOCK for 60 steps, then RECOVER. Block and lunge latched together from REST → BLOCK.
- ATTACK with sabers_colliding=1 → RECOVER next step, scored_out=0. ATTACK with no release for 30 steps → forced RECOVER.
- opponent_scored_in on 5 steps → health 4,3,2,1,0. At 0: game_over_out=1, state locked to 00 despite further lunge presses. A 6th opponent_scored step leaves health at 0.
- rst_n_in pulsed low mid-ATTACK (asynchronous, no clock edge) → outputs clear immediately, health=5. ir_valid_in coincident with step_in → the button is honoured on that step and is not reapplied on the next step.
